ram_frame_writer: RTL and testbench

- Writer-side master for the shared frame RAM that the VGA scan-out path reads.
- Accepts a byte stream over a valid/ready handshake and packs each 4 bytes into one 32-bit word, little-endian.
- Issues single-cycle RAM writes (data, address, write-enable) at consecutive addresses starting at BASE_ADDR.
- Raises wr_mode while it owns the RAM write port, so the top level can mux it in place of the manual data/topAddrs/sw2 path.

---
 rtl/ram_frame_writer.sv | 202 ++++++++++++++++++++
 tb/tb_ram_frame_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_frame_writer.sv
// ram_frame_writer: writer-side master for the shared frame RAM.
// Packs a valid/ready byte stream little-endian into DATA_W-bit words and
// issues single-cycle RAM writes at BASE_ADDR, BASE_ADDR+1, ... for
// NUM_WORDS words. wr_mode tells the top level to mux this writer onto the
// RAM write port in place of the manual path.
// Optional feature macro: RAM_WR_CHECKSUM_EN (running 32-bit sum of written
// words on checksum; tied to zero when undefined).
module ram_frame_writer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = 10000,
    parameter int NUM_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wr_mode,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0]  LAST_LANE = IDX_W'(LANES - 1);
    localparam logic [15:0]       LAST_WORD = 16'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                xfer_s;
    logic [IDX_W-1:0]    byte_idx_r;
    logic [15:0]         word_cnt_r;
    logic [DATA_W-1:0]   word_r;
    logic [DATA_W-1:0]   assembled_s;

    logic                in_ready_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                wr_mode_r;
    logic                busy_r;
    logic                done_r;

    // Next-state decode; xfer_s flags a byte handshake in FILL.
    always_comb begin
        next_state_s = state_r;
        xfer_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FILL;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                xfer_s = in_valid & in_ready_r;
                if (xfer_s && (byte_idx_r == LAST_LANE)) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (word_cnt_r == LAST_WORD) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Current word with the incoming byte merged into lane byte_idx, so the
    // final lane can be written to RAM on the very next cycle.
    always_comb begin
        assembled_s = word_r;
        assembled_s[{byte_idx_r, 3'b000} +: 8] = in_byte;
    end

    // FSM state register; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath and registered outputs, all derived from the upcoming state
    // so every output changes exactly on the edge that enters a state.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_r <= '0;
            word_cnt_r <= 16'd0;
            word_r     <= '0;
            in_ready_r <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            wr_mode_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= (next_state_s == ST_FILL);
            we_r       <= (next_state_s == ST_WRITE);
            busy_r     <= (next_state_s != ST_IDLE);
            wr_mode_r  <= (next_state_s != ST_IDLE);
            done_r     <= (next_state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        byte_idx_r <= '0;
                        word_cnt_r <= 16'd0;
                        word_r     <= '0;
                    end
                end
                ST_FILL: begin
                    if (xfer_s) begin
                        word_r <= assembled_s;
                        if (byte_idx_r == LAST_LANE) begin
                            byte_idx_r <= '0;
                            addr_r     <= BASE + ADDR_W'(word_cnt_r);
                            wdata_r    <= assembled_s;
                        end else begin
                            byte_idx_r <= byte_idx_r + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (word_cnt_r != LAST_WORD) begin
                        word_cnt_r <= word_cnt_r + 16'd1;
                        byte_idx_r <= '0;
                    end
                end
                ST_DONE: begin
                    byte_idx_r <= '0;
                end
                default: begin
                    byte_idx_r <= '0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign we       = we_r;
    assign addr     = addr_r;
    assign wdata    = wdata_r;
    assign wr_mode  = wr_mode_r;
    assign busy     = busy_r;
    assign done     = done_r;

`ifdef RAM_WR_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Modulo-2^32 accumulation of one written word.
    function automatic logic [31:0] csum_add(input logic [31:0] acc,
                                             input logic [DATA_W-1:0] w);
        return acc + 32'(w);
    endfunction

    // Sum of written words: cleared when a transfer is accepted, updated in
    // each WRITE cycle, then held until the next start or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_r <= 32'h0000_0000;
        end else if ((state_r == ST_IDLE) && start) begin
            checksum_r <= 32'h0000_0000;
        end else if (state_r == ST_WRITE) begin
            checksum_r <= csum_add(checksum_r, wdata_r);
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_ram_frame_writer.sv
// Directed self-checking bench for ram_frame_writer. Two instances share the
// byte bus: one with NUM_WORDS=1 and one with NUM_WORDS=2. Expected RAM
// writes are queued when a transfer is set up and compared whenever we rises.
module tb_ram_frame_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2;
    logic        in_valid;
    logic [7:0]  in_byte;

    logic        rdy1, we1, wrm1, busy1, done1;
    logic [31:0] addr1, wdata1, cs1;
    logic        rdy2, we2, wrm2, busy2, done2;
    logic [31:0] addr2, wdata2, cs2;

    int n_assert = 0;
    int n_fail   = 0;
    int we_cnt1 = 0, done_cnt1 = 0, we_cnt2 = 0, done_cnt2 = 0;
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    always #5 clk = ~clk;

    ram_frame_writer #(.NUM_WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(rdy1), .we(we1), .addr(addr1),
        .wdata(wdata1), .wr_mode(wrm1), .busy(busy1), .done(done1),
        .checksum(cs1)
    );

    ram_frame_writer #(.NUM_WORDS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(rdy2), .we(we2), .addr(addr2),
        .wdata(wdata2), .wr_mode(wrm2), .busy(busy2), .done(done2),
        .checksum(cs2)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and score any RAM write.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (we1) begin
            if (q1.size() == 0) begin
                check("we1_unexpected", 64'(q1.size()), 64'd1);
            end else begin
                e = q1.pop_front();
                check("wr1", {addr1, wdata1}, e);
            end
        end
        if (we2) begin
            if (q2.size() == 0) begin
                check("we2_unexpected", 64'(q2.size()), 64'd1);
            end else begin
                e = q2.pop_front();
                check("wr2", {addr2, wdata2}, e);
            end
        end
        we_cnt1   += int'(we1);
        done_cnt1 += int'(done1);
        we_cnt2   += int'(we2);
        done_cnt2 += int'(done2);
    endtask

    // Offer one byte until the selected instance accepts it (bounded).
    task automatic send(input int sel, input logic [7:0] b);
        int   guard;
        logic acc;
        guard    = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!acc && guard < 20) begin
            acc = (sel == 1) ? rdy1 : rdy2;
            tick();
            guard++;
        end
        check("byte_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_cs;

        // Reset with start and in_valid held high: reset must win.
        rst = 1'b1; start1 = 1'b1; start2 = 1'b1; in_valid = 1'b1; in_byte = 8'h5A;
        tick();
        tick();
        check("rst_ctl1", {59'd0, we1, rdy1, busy1, wrm1, done1}, 64'd0);
        check("rst_ctl2", {59'd0, we2, rdy2, busy2, wrm2, done2}, 64'd0);
        check("rst_addr_data2", {addr2, wdata2}, 64'd0);
        check("rst_cs2", 64'(cs2), 64'd0);
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0; in_valid = 1'b0;
        tick();
        check("idle_after_rst", {62'd0, busy2, rdy2}, 64'd0);

        // Single word on the NUM_WORDS=1 instance.
        pulse_start(1);
        check("t1_busy_wrmode", {62'd0, busy1, wrm1}, 64'd3);
        q1.push_back({32'd10000, 32'h0000_0032});
        send(1, 8'h32); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
        check("t1_write_latency", 64'(q1.size()), 64'd0);
        tick();
        check("t1_done", 64'(done1), 64'd1);
        tick();
        check("t1_idle", {61'd0, wrm1, busy1, done1}, 64'd0);
        check("t1_hold", {addr1, wdata1}, {32'd10000, 32'h0000_0032});
        check("t1_counts", {32'(we_cnt1), 32'(done_cnt1)}, {32'd1, 32'd1});

        // Two words with a 3-cycle stall mid-word.
        we_cnt2 = 0; done_cnt2 = 0;
        pulse_start(2);
        q2.push_back({32'd10000, 32'h0000_0032});
        q2.push_back({32'd10001, 32'h0000_0064});
        send(2, 8'h32); send(2, 8'h00);
        tick(); tick(); tick();
        send(2, 8'h00); send(2, 8'h00);
        send(2, 8'h64); send(2, 8'h00); send(2, 8'h00); send(2, 8'h00);
        tick();
        check("t2_done", 64'(done2), 64'd1);
`ifdef RAM_WR_CHECKSUM_EN
        exp_cs = 32'h0000_0096;
`else
        exp_cs = 32'h0000_0000;
`endif
        check("t2_checksum", 64'(cs2), 64'(exp_cs));
        tick(); tick(); tick();
        check("t2_counts", {32'(we_cnt2), 32'(done_cnt2)}, {32'd2, 32'd1});
        check("t2_queue_empty", 64'(q2.size()), 64'd0);

        // Start ignored mid-transfer; byte offered during WRITE waits.
        we_cnt2 = 0; done_cnt2 = 0;
        pulse_start(2);
        q2.push_back({32'd10000, 32'h4433_2211});
        q2.push_back({32'd10001, 32'h8877_6655});
        send(2, 8'h11); send(2, 8'h22);
        pulse_start(2);
        send(2, 8'h33); send(2, 8'h44);
        in_valid = 1'b1; in_byte = 8'h55;
        check("t3_rdy_in_write", {62'd0, we2, rdy2}, 64'd2);
        send(2, 8'h55); send(2, 8'h66); send(2, 8'h77); send(2, 8'h88);
        tick(); tick();
        check("t3_counts", {32'(we_cnt2), 32'(done_cnt2)}, {32'd2, 32'd1});
        check("t3_queue_empty", 64'(q2.size()), 64'd0);

        // Reset after 2 bytes of word 1; restart from BASE_ADDR.
        we_cnt2 = 0; done_cnt2 = 0;
        pulse_start(2);
        q2.push_back({32'd10000, 32'h0403_0201});
        send(2, 8'h01); send(2, 8'h02); send(2, 8'h03); send(2, 8'h04);
        send(2, 8'h05); send(2, 8'h06);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t4_no_partial_write", 64'(we_cnt2), 64'd1);
        check("t4_rst_state", {busy2, rdy2, addr2}, 34'd0);
        pulse_start(2);
        q2.push_back({32'd10000, 32'hDDCC_BBAA});
        q2.push_back({32'd10001, 32'h0403_0201});
        send(2, 8'hAA); send(2, 8'hBB); send(2, 8'hCC); send(2, 8'hDD);
        send(2, 8'h01); send(2, 8'h02); send(2, 8'h03); send(2, 8'h04);
        tick(); tick();
        check("t4_queue_empty", 64'(q2.size()), 64'd0);

        // Checksum wraps modulo 2^32.
        pulse_start(2);
        q2.push_back({32'd10000, 32'hFFFF_FFFF});
        q2.push_back({32'd10001, 32'h0000_0002});
        send(2, 8'hFF); send(2, 8'hFF); send(2, 8'hFF); send(2, 8'hFF);
        send(2, 8'h02); send(2, 8'h00); send(2, 8'h00); send(2, 8'h00);
        tick();
        check("t5_done", 64'(done2), 64'd1);
`ifdef RAM_WR_CHECKSUM_EN
        exp_cs = 32'h0000_0001;
`else
        exp_cs = 32'h0000_0000;
`endif
        check("t5_checksum", 64'(cs2), 64'(exp_cs));
        tick(); tick();
        check("t5_checksum_held", 64'(cs2), 64'(exp_cs));
        check("t5_queue_empty", 64'(q2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
